// File: rtl/regfile_scoreboard_if.sv
// Bundle of the regfile/scoreboard signals shared by decode, issue and writeback.
// The master side (core or bench) drives addresses, issue and writeback requests.
// The slave side (regfile_scoreboard) returns operands, hazard status and debug taps.
interface regfile_scoreboard_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2
);
  logic [NUM_READ*ADDRESS_WIDTH-1:0] AD_R;
  logic [NUM_READ*DATA_WIDTH-1:0]    RD;
  logic [NUM_READ-1:0]               RD_VALID;
  logic                              ISSUE_EN;
  logic [ADDRESS_WIDTH-1:0]          ISSUE_AD;
  logic                              ISSUE_READY;
  logic                              WE3;
  logic [ADDRESS_WIDTH-1:0]          AD3;
  logic [DATA_WIDTH-1:0]             WD3;
  logic                              FLUSH;
  logic [ADDRESS_WIDTH:0]            busy_count;
  logic [DATA_WIDTH-1:0]             a0;
  logic [DATA_WIDTH-1:0]             a1;
  logic [DATA_WIDTH-1:0]             a7;

  modport master (
    output AD_R, ISSUE_EN, ISSUE_AD, WE3, AD3, WD3, FLUSH,
    input  RD, RD_VALID, ISSUE_READY, busy_count, a0, a1, a7
  );

  modport slave (
    input  AD_R, ISSUE_EN, ISSUE_AD, WE3, AD3, WD3, FLUSH,
    output RD, RD_VALID, ISSUE_READY, busy_count, a0, a1, a7
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with NUM_READ combinational read ports and a per-register
// pending-write counter used by the hazard unit. Issue marks a destination busy,
// writeback retires one pending write and stores the data. FLUSH drops all
// pending marks. x0 is hardwired to zero and never becomes busy.
// Optional feature: define REGFILE_BYPASS_EN to forward the writeback data to a
// read port addressing the same register in the same cycle.
module regfile_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_READ      = 2,
  parameter int CNT_WIDTH     = 2
) (
  input logic               clk,
  input logic               rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int BW    = ADDRESS_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0]          regs    [DEPTH];
  logic [CNT_WIDTH-1:0]           cnt     [DEPTH];
  logic [CNT_WIDTH-1:0]           cnt_nxt [DEPTH];
  logic [BW-1:0]                  busy_q;
  logic [BW-1:0]                  busy_nxt;
  logic                           issue_ready;
  logic                           wr_en;
  logic                           issue_hit;
  logic                           wb_hit;
  logic [ADDRESS_WIDTH-1:0]       rd_ad;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_bus;
  logic [NUM_READ-1:0]            rd_vld;

  assign wr_en       = bus.WE3 && (bus.AD3 != '0);
  assign issue_ready = (bus.ISSUE_AD == '0) || (cnt[bus.ISSUE_AD] != CNT_MAX);

  // Next counter value per register and the popcount of busy registers after the edge
  always_comb begin
    busy_nxt  = '0;
    issue_hit = 1'b0;
    wb_hit    = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      issue_hit  = bus.ISSUE_EN && (bus.ISSUE_AD == ADDRESS_WIDTH'(r)) && (r != 0);
      wb_hit     = bus.WE3 && (bus.AD3 == ADDRESS_WIDTH'(r)) && (r != 0);
      cnt_nxt[r] = cnt[r];
      if (bus.FLUSH) begin
        cnt_nxt[r] = '0;
      end else if (issue_hit && wb_hit) begin
        cnt_nxt[r] = cnt[r];
      end else if (issue_hit) begin
        if (issue_ready) cnt_nxt[r] = cnt[r] + CNT_WIDTH'(1);
      end else if (wb_hit) begin
        if (cnt[r] != '0) cnt_nxt[r] = cnt[r] - CNT_WIDTH'(1);
      end
      if (cnt_nxt[r] != '0) busy_nxt = busy_nxt + BW'(1);
    end
  end

  // Operand read: array value, optionally overridden by a same-cycle writeback
  always_comb begin
    rd_bus = '0;
    rd_vld = '0;
    rd_ad  = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_ad = bus.AD_R[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      rd_bus[i*DATA_WIDTH +: DATA_WIDTH] = regs[rd_ad];
      rd_vld[i] = (cnt[rd_ad] == '0);
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (bus.AD3 == rd_ad)) begin
        rd_bus[i*DATA_WIDTH +: DATA_WIDTH] = bus.WD3;
        rd_vld[i] = (cnt[rd_ad] <= CNT_WIDTH'(1));
      end
`endif
    end
  end

  // Register array, pending counters and busy popcount; reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) regs[bus.AD3] <= bus.WD3;
      for (int r = 0; r < DEPTH; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      busy_q <= busy_nxt;
    end
  end

  assign bus.RD          = rd_bus;
  assign bus.RD_VALID    = rd_vld;
  assign bus.ISSUE_READY = issue_ready;
  assign bus.busy_count  = busy_q;
  assign bus.a0          = regs[10];
  assign bus.a1          = regs[11];
  assign bus.a7          = regs[17];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a rule-level reference model
// and a per-cycle compare process, plus hand-computed literal expectations.
module tb_regfile_scoreboard;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 2;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus ();

  regfile_scoreboard #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register contents and pending-write counts
  logic [DW-1:0] m_reg [32];
  int            m_cnt [32];

  function automatic bit m_iss(input int r);
    return bus.ISSUE_EN && (int'(bus.ISSUE_AD) == r) && (r != 0);
  endfunction

  function automatic bit m_wb(input int r);
    return bus.WE3 && (int'(bus.AD3) == r) && (r != 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] <= '0;
        m_cnt[r] <= 0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (bus.FLUSH) m_cnt[r] <= 0;
        else if (m_iss(r) && m_wb(r)) m_cnt[r] <= m_cnt[r];
        else if (m_iss(r)) begin
          if (m_cnt[r] < CMAX) m_cnt[r] <= m_cnt[r] + 1;
        end else if (m_wb(r)) begin
          if (m_cnt[r] > 0) m_cnt[r] <= m_cnt[r] - 1;
        end
      end
      if (bus.WE3 && bus.AD3 != 0) m_reg[bus.AD3] <= bus.WD3;
    end
  end

  // Per-cycle compare of every output against the model
  int            c_busy;
  int            c_a;
  logic [DW-1:0] c_rd;
  logic          c_v;
  always @(negedge clk) begin
    c_busy = 0;
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) c_busy++;
    for (int i = 0; i < NR; i++) begin
      c_a  = int'(bus.AD_R[i*AW +: AW]);
      c_rd = (c_a == 0) ? '0 : m_reg[c_a];
      c_v  = (m_cnt[c_a] == 0);
`ifdef REGFILE_BYPASS_EN
      if (bus.WE3 && bus.AD3 != 0 && int'(bus.AD3) == c_a) begin
        c_rd = bus.WD3;
        c_v  = (m_cnt[c_a] <= 1);
      end
`endif
      chk("model rd", 64'(bus.RD[i*DW +: DW]), 64'(c_rd));
      chk("model rd_valid", 64'(bus.RD_VALID[i]), 64'(c_v));
    end
    chk("model issue_ready", 64'(bus.ISSUE_READY),
        64'((bus.ISSUE_AD == 0) || (m_cnt[bus.ISSUE_AD] < CMAX)));
    chk("model busy_count", 64'(bus.busy_count), 64'(c_busy));
    chk("model a0", 64'(bus.a0), 64'(m_reg[10]));
    chk("model a1", 64'(bus.a1), 64'(m_reg[11]));
    chk("model a7", 64'(bus.a7), 64'(m_reg[17]));
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.ISSUE_EN = 1'b0;
    bus.ISSUE_AD = '0;
    bus.WE3      = 1'b0;
    bus.AD3      = '0;
    bus.WD3      = '0;
    bus.FLUSH    = 1'b0;
  endtask

  task automatic rdp(input int p0, input int p1);
    bus.AD_R = {AW'(p1), AW'(p0)};
  endtask

  task automatic issue(input int ad);
    bus.ISSUE_EN = 1'b1;
    bus.ISSUE_AD = AW'(ad);
  endtask

  task automatic wb(input int ad, input logic [DW-1:0] d);
    bus.WE3 = 1'b1;
    bus.AD3 = AW'(ad);
    bus.WD3 = d;
  endtask

  initial begin
    idle();
    rdp(5, 0);
    rst_n = 1'b0;
    #1;
    chk("reset rd", 64'(bus.RD), 64'h0);
    chk("reset rd_valid", 64'(bus.RD_VALID), 64'h3);
    chk("reset issue_ready", 64'(bus.ISSUE_READY), 64'h1);
    chk("reset busy_count", 64'(bus.busy_count), 64'h0);
    chk("reset a0", 64'(bus.a0), 64'h0);
    go();
    go();
    rst_n = 1'b1;

    // issue x3, writeback two cycles later
    rdp(3, 3);
    issue(3);
    look();
    chk("t2 valid before issue", 64'(bus.RD_VALID[0]), 64'h1);
    go();
    idle();
    look();
    chk("t2 valid after issue", 64'(bus.RD_VALID), 64'h0);
    chk("t2 busy after issue", 64'(bus.busy_count), 64'h1);
    go();
    wb(3, 32'hDEADBEEF);
    look();
`ifndef REGFILE_BYPASS_EN
    chk("t2 valid during wb", 64'(bus.RD_VALID[0]), 64'h0);
    chk("t2 rd during wb", 64'(bus.RD[31:0]), 64'h0);
`endif
    go();
    idle();
    look();
    chk("t2 rd after wb", 64'(bus.RD[31:0]), 64'hDEADBEEF);
    chk("t2 valid after wb", 64'(bus.RD_VALID), 64'h3);
    chk("t2 busy after wb", 64'(bus.busy_count), 64'h0);

    // saturate x7, 4th issue ignored, three writebacks to clear
    rdp(7, 3);
    issue(7);
    go();
    go();
    go();
    look();
    chk("t3 ready saturated", 64'(bus.ISSUE_READY), 64'h0);
    chk("t3 valid busy", 64'(bus.RD_VALID[0]), 64'h0);
    chk("t3 busy one reg", 64'(bus.busy_count), 64'h1);
    go();
    idle();
    bus.ISSUE_AD = AW'(7);
    look();
    chk("t3 ready after 4th issue", 64'(bus.ISSUE_READY), 64'h0);
    wb(7, 32'h1);
    go();
    wb(7, 32'h2);
    go();
    bus.WE3 = 1'b0;
    look();
    chk("t3 valid one left", 64'(bus.RD_VALID[0]), 64'h0);
    chk("t3 ready one left", 64'(bus.ISSUE_READY), 64'h1);
    wb(7, 32'h3);
    go();
    idle();
    look();
    chk("t3 valid cleared", 64'(bus.RD_VALID[0]), 64'h1);
    chk("t3 rd x7", 64'(bus.RD[31:0]), 64'h3);
    chk("t3 busy cleared", 64'(bus.busy_count), 64'h0);

    // simultaneous issue+wb keeps count; flush beats issue
    rdp(9, 4);
    issue(9);
    go();
    idle();
    look();
    chk("t4 busy x9", 64'(bus.busy_count), 64'h1);
    issue(9);
    wb(9, 32'h99);
    go();
    idle();
    look();
    chk("t4 valid net zero", 64'(bus.RD_VALID[0]), 64'h0);
    chk("t4 rd x9", 64'(bus.RD[31:0]), 64'h99);
    chk("t4 busy net zero", 64'(bus.busy_count), 64'h1);
    issue(4);
    go();
    look();
    chk("t4 busy two", 64'(bus.busy_count), 64'h2);
    chk("t4 valid both busy", 64'(bus.RD_VALID), 64'h0);
    bus.FLUSH = 1'b1;
    wb(12, 32'h12);
    go();
    idle();
    rdp(4, 12);
    look();
    chk("t4 valid after flush", 64'(bus.RD_VALID), 64'h3);
    chk("t4 busy after flush", 64'(bus.busy_count), 64'h0);
    chk("t4 flush keeps wb data", 64'(bus.RD[63:32]), 64'h12);

    // x0 writes dropped and never busy
    rdp(0, 20);
    issue(20);
    go();
    idle();
    look();
    chk("t5 busy x20", 64'(bus.busy_count), 64'h1);
    wb(0, 32'hFFFFFFFF);
    issue(0);
    look();
    chk("t5 ready x0", 64'(bus.ISSUE_READY), 64'h1);
    go();
    idle();
    look();
    chk("t5 rd x0", 64'(bus.RD[31:0]), 64'h0);
    chk("t5 valid x0", 64'(bus.RD_VALID[0]), 64'h1);
    chk("t5 busy unchanged", 64'(bus.busy_count), 64'h1);

    // mid-run reset with pending writes
    rdp(5, 20);
    wb(5, 32'h1234);
    go();
    idle();
    issue(5);
    go();
    go();
    idle();
    look();
    chk("t1 rd x5 before reset", 64'(bus.RD[31:0]), 64'h1234);
    chk("t1 valid before reset", 64'(bus.RD_VALID), 64'h0);
    chk("t1 busy before reset", 64'(bus.busy_count), 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1 rd in reset", 64'(bus.RD), 64'h0);
    chk("t1 valid in reset", 64'(bus.RD_VALID), 64'h3);
    chk("t1 busy in reset", 64'(bus.busy_count), 64'h0);
    chk("t1 ready in reset", 64'(bus.ISSUE_READY), 64'h1);
    go();
    rst_n = 1'b1;
    look();
    chk("t1 rd after reset", 64'(bus.RD), 64'h0);
    chk("t1 valid after reset", 64'(bus.RD_VALID), 64'h3);
    chk("t1 busy after reset", 64'(bus.busy_count), 64'h0);

    // writeback into a read operand and the debug taps
    rdp(10, 11);
    issue(10);
    go();
    idle();
    wb(10, 32'hA5);
    look();
`ifdef REGFILE_BYPASS_EN
    chk("t6 bypass rd", 64'(bus.RD[31:0]), 64'hA5);
    chk("t6 bypass valid", 64'(bus.RD_VALID[0]), 64'h1);
`else
    chk("t6 no bypass rd", 64'(bus.RD[31:0]), 64'h0);
    chk("t6 no bypass valid", 64'(bus.RD_VALID[0]), 64'h0);
`endif
    go();
    idle();
    look();
    chk("t6 a0", 64'(bus.a0), 64'hA5);
    chk("t6 valid after wb", 64'(bus.RD_VALID[0]), 64'h1);
    wb(11, 32'h1111);
    go();
    wb(17, 32'h1717);
    go();
    idle();
    look();
    chk("tap a1", 64'(bus.a1), 64'h1111);
    chk("tap a7", 64'(bus.a7), 64'h1717);
    go();
    go();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
